// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl -- four-channel duty fader that feeds a pwm_core.
//
// Each channel holds a latched target, step and interval. While it is fading,
// every INTERVAL pwm periods (counted on PWM_PERIOD_END[n]) it raises a pending
// request. One shared update unit, granted round-robin, moves the channel duty
// one step toward its target. It never overshoots the target and never wraps.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   PWM_PERIOD_END[3:0] per-channel period-wrap pulse from pwm_core
//   CMD_VALID/CMD_READY fade command handshake; CMD_READY = !FADE_BUSY[CMD_CH]
//   CMD_CH              channel addressed by the command
//   CMD_TARGET          final duty
//   CMD_STEP            duty increment per update (0 = jump straight to target)
//   CMD_INTERVAL        pwm periods between updates (0 behaves as 1)
//   FADE_ABORT[3:0]     per-channel abort pulse
//   PWM_DUTY0..3        registered duty outputs
//   FADE_BUSY[3:0]      channel is fading
//   FADE_DONE[3:0]      one-cycle pulse when a fade reaches its target
module pwm_fade_ctrl #(
  parameter int P_DUTY_W = 16,
  parameter int P_CNT_W  = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [3:0]          PWM_PERIOD_END,
  input  logic                CMD_VALID,
  output logic                CMD_READY,
  input  logic [1:0]          CMD_CH,
  input  logic [P_DUTY_W-1:0] CMD_TARGET,
  input  logic [P_CNT_W-1:0]  CMD_STEP,
  input  logic [P_CNT_W-1:0]  CMD_INTERVAL,
  input  logic [3:0]          FADE_ABORT,
  output logic [P_DUTY_W-1:0] PWM_DUTY0,
  output logic [P_DUTY_W-1:0] PWM_DUTY1,
  output logic [P_DUTY_W-1:0] PWM_DUTY2,
  output logic [P_DUTY_W-1:0] PWM_DUTY3,
  output logic [3:0]          FADE_BUSY,
  output logic [3:0]          FADE_DONE
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_FADING = 1'b1;

  localparam logic [P_CNT_W-1:0] INTV_MIN = 1;
  localparam logic [P_CNT_W:0]   CNT_ONE  = 1;

  // Result of one update: {finished, new_duty}. The distance to the target is
  // taken in P_DUTY_W+1-bit signed arithmetic, so a step that would pass the
  // target is turned into a final jump onto it.
  // The step is zero-extended into the duty width, so P_CNT_W <= P_DUTY_W.
  function automatic logic [P_DUTY_W:0] fade_step(
    input logic [P_DUTY_W-1:0] d,
    input logic [P_DUTY_W-1:0] t,
    input logic [P_CNT_W-1:0]  s
  );
    logic signed [P_DUTY_W:0] diff;
    logic signed [P_DUTY_W:0] mag;
    logic signed [P_DUTY_W:0] s_ext;
    diff  = $signed({1'b0, t}) - $signed({1'b0, d});
    mag   = (diff < 0) ? -diff : diff;
    s_ext = $signed({{(P_DUTY_W + 1 - P_CNT_W){1'b0}}, s});
    if ((s == '0) || (mag <= s_ext)) begin
      fade_step = {1'b1, t};
    end else if (diff > 0) begin
      fade_step = {1'b0, d + s_ext[P_DUTY_W-1:0]};
    end else begin
      fade_step = {1'b0, d - s_ext[P_DUTY_W-1:0]};
    end
  endfunction

  logic [0:0]          state_q [4];
  logic [0:0]          state_d [4];
  logic [P_DUTY_W-1:0] duty_q  [4];
  logic [P_DUTY_W-1:0] duty_d  [4];
  logic [P_DUTY_W-1:0] tgt_q   [4];
  logic [P_DUTY_W-1:0] tgt_d   [4];
  logic [P_CNT_W-1:0]  step_q  [4];
  logic [P_CNT_W-1:0]  step_d  [4];
  logic [P_CNT_W-1:0]  intv_q  [4];
  logic [P_CNT_W-1:0]  intv_d  [4];
  logic [P_CNT_W-1:0]  cnt_q   [4];
  logic [P_CNT_W-1:0]  cnt_d   [4];
  logic [3:0]          pend_q;
  logic [3:0]          pend_d;
  logic [3:0]          done_q;
  logic [3:0]          done_d;
  // Channel holding highest arbitration priority (one past the last grant).
  logic [1:0]          ptr_q;
  logic [1:0]          ptr_d;

  logic [3:0]          busy;
  logic [3:0]          req;
  logic                gnt_vld;
  logic [1:0]          gnt_idx;
  logic                cmd_acc;

  always_comb begin
    for (int n = 0; n < 4; n++) begin
      busy[n] = (state_q[n] == ST_FADING);
    end
  end

  assign CMD_READY = !busy[CMD_CH];
  assign cmd_acc   = CMD_VALID && CMD_READY;
  // An aborting channel drops out of arbitration so the slot can go elsewhere.
  assign req       = pend_q & ~FADE_ABORT;

  // Round-robin arbiter: scan from ptr_q upward, first requester wins.
  always_comb begin
    logic [1:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
    ptr_d = gnt_vld ? (gnt_idx + 2'd1) : ptr_q;
  end

  always_comb begin
    logic              evt;
    logic [P_CNT_W:0]  cnt_inc;
    logic [P_DUTY_W:0] res;
    evt     = 1'b0;
    cnt_inc = '0;
    res     = '0;
    pend_d  = pend_q;
    done_d  = '0;
    for (int n = 0; n < 4; n++) begin
      state_d[n] = state_q[n];
      duty_d[n]  = duty_q[n];
      tgt_d[n]   = tgt_q[n];
      step_d[n]  = step_q[n];
      intv_d[n]  = intv_q[n];
      cnt_d[n]   = cnt_q[n];
      evt        = 1'b0;
      cnt_inc    = {1'b0, cnt_q[n]} + CNT_ONE;
      res        = fade_step(duty_q[n], tgt_q[n], step_q[n]);

      if (state_q[n] == ST_FADING) begin
        if (PWM_PERIOD_END[n]) begin
          if (cnt_inc == {1'b0, intv_q[n]}) begin
            cnt_d[n] = '0;
            evt      = 1'b1;
          end else begin
            cnt_d[n] = cnt_inc[P_CNT_W-1:0];
          end
        end
        // A second event before service simply leaves the flag set.
        pend_d[n] = pend_q[n] | evt;

        if (gnt_vld && (gnt_idx == 2'(n))) begin
          duty_d[n] = res[P_DUTY_W-1:0];
          pend_d[n] = evt;
          if (res[P_DUTY_W]) begin
            state_d[n] = ST_IDLE;
            done_d[n]  = 1'b1;
            pend_d[n]  = 1'b0;
            cnt_d[n]   = '0;
          end
        end

        if (FADE_ABORT[n]) begin
          state_d[n] = ST_IDLE;
          duty_d[n]  = duty_q[n];
          done_d[n]  = 1'b0;
          pend_d[n]  = 1'b0;
          cnt_d[n]   = '0;
        end
      end else if (cmd_acc && (CMD_CH == 2'(n)) && !FADE_ABORT[n]) begin
        state_d[n] = ST_FADING;
        tgt_d[n]   = CMD_TARGET;
        step_d[n]  = CMD_STEP;
        intv_d[n]  = (CMD_INTERVAL == '0) ? INTV_MIN : CMD_INTERVAL;
        cnt_d[n]   = '0;
        pend_d[n]  = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= ST_IDLE;
        duty_q[n]  <= '0;
        tgt_q[n]   <= '0;
        step_q[n]  <= '0;
        intv_q[n]  <= '0;
        cnt_q[n]   <= '0;
      end
      pend_q <= '0;
      done_q <= '0;
      ptr_q  <= '0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        state_q[n] <= state_d[n];
        duty_q[n]  <= duty_d[n];
        tgt_q[n]   <= tgt_d[n];
        step_q[n]  <= step_d[n];
        intv_q[n]  <= intv_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
      pend_q <= pend_d;
      done_q <= done_d;
      ptr_q  <= ptr_d;
    end
  end

  assign PWM_DUTY0 = duty_q[0];
  assign PWM_DUTY1 = duty_q[1];
  assign PWM_DUTY2 = duty_q[2];
  assign PWM_DUTY3 = duty_q[3];
  assign FADE_BUSY = busy;
  assign FADE_DONE = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl: ramp up/down, parameter corner cases,
// handshake, round-robin contention, abort and asynchronous reset.
module tb_pwm_fade_ctrl;

  logic        CLK;
  logic        RST_N;
  logic [3:0]  PWM_PERIOD_END;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [1:0]  CMD_CH;
  logic [15:0] CMD_TARGET;
  logic [7:0]  CMD_STEP;
  logic [7:0]  CMD_INTERVAL;
  logic [3:0]  FADE_ABORT;
  logic [15:0] PWM_DUTY0;
  logic [15:0] PWM_DUTY1;
  logic [15:0] PWM_DUTY2;
  logic [15:0] PWM_DUTY3;
  logic [3:0]  FADE_BUSY;
  logic [3:0]  FADE_DONE;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_fade_ctrl #(.P_DUTY_W(16), .P_CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .PWM_PERIOD_END(PWM_PERIOD_END),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_CH(CMD_CH),
    .CMD_TARGET(CMD_TARGET), .CMD_STEP(CMD_STEP), .CMD_INTERVAL(CMD_INTERVAL),
    .FADE_ABORT(FADE_ABORT), .PWM_DUTY0(PWM_DUTY0), .PWM_DUTY1(PWM_DUTY1),
    .PWM_DUTY2(PWM_DUTY2), .PWM_DUTY3(PWM_DUTY3), .FADE_BUSY(FADE_BUSY),
    .FADE_DONE(FADE_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One period-end pulse edge followed by one quiet edge, so a pending
  // request raised by the pulse has been serviced when this returns.
  task automatic pulse(input logic [3:0] m);
    PWM_PERIOD_END = m;
    tick();
    PWM_PERIOD_END = '0;
    tick();
  endtask

  task automatic send(input logic [1:0] ch, input logic [15:0] t,
                      input logic [7:0] s, input logic [7:0] i);
    CMD_CH = ch; CMD_TARGET = t; CMD_STEP = s; CMD_INTERVAL = i;
    CMD_VALID = 1'b1;
    tick();
    CMD_VALID = 1'b0;
  endtask

  initial begin
    RST_N = 1'b0; PWM_PERIOD_END = '0; CMD_VALID = 1'b0; CMD_CH = '0;
    CMD_TARGET = '0; CMD_STEP = '0; CMD_INTERVAL = '0; FADE_ABORT = '0;
    #12;
    chk("rst_duty0", 32'(PWM_DUTY0), 32'h0);
    chk("rst_busy", 32'(FADE_BUSY), 32'h0);
    chk("rst_done", 32'(FADE_DONE), 32'h0);
    chk("rst_ready", 32'(CMD_READY), 32'h1);
    RST_N = 1'b1;
    tick();

    // Ramp up on ch0: 30, 60, 90, 100 after pulses 2, 4, 6, 8.
    send(2'd0, 16'd100, 8'd30, 8'd2);
    chk("up_busy", 32'(FADE_BUSY), 32'h1);
    chk("up_accept_duty", 32'(PWM_DUTY0), 32'd0);
    pulse(4'h1);
    chk("up_p1", 32'(PWM_DUTY0), 32'd0);
    pulse(4'h1);
    chk("up_p2", 32'(PWM_DUTY0), 32'd30);
    pulse(4'h1); pulse(4'h1);
    chk("up_p4", 32'(PWM_DUTY0), 32'd60);
    pulse(4'h1); pulse(4'h1);
    chk("up_p6", 32'(PWM_DUTY0), 32'd90);
    chk("up_p6_done", 32'(FADE_DONE), 32'h0);
    pulse(4'h1); pulse(4'h1);
    chk("up_p8", 32'(PWM_DUTY0), 32'd100);
    chk("up_p8_done", 32'(FADE_DONE), 32'h1);
    chk("up_p8_busy", 32'(FADE_BUSY), 32'h0);
    tick();
    chk("up_done_1cyc", 32'(FADE_DONE), 32'h0);

    // Ramp down without overshoot: 60, 20, 5.
    send(2'd0, 16'd5, 8'd40, 8'd1);
    pulse(4'h1);
    chk("dn_1", 32'(PWM_DUTY0), 32'd60);
    pulse(4'h1);
    chk("dn_2", 32'(PWM_DUTY0), 32'd20);
    pulse(4'h1);
    chk("dn_3", 32'(PWM_DUTY0), 32'd5);
    chk("dn_done", 32'(FADE_DONE), 32'h1);

    // step=0: a single jump at the first full interval.
    send(2'd1, 16'hFFFF, 8'd0, 8'd3);
    pulse(4'h2); pulse(4'h2);
    chk("s0_wait", 32'(PWM_DUTY1), 32'h0);
    pulse(4'h2);
    chk("s0_jump", 32'(PWM_DUTY1), 32'hFFFF);
    chk("s0_done", 32'(FADE_DONE), 32'h2);

    // interval=0: update on every period end.
    send(2'd2, 16'd10, 8'd3, 8'd0);
    pulse(4'h4);
    chk("i0_1", 32'(PWM_DUTY2), 32'd3);
    pulse(4'h4);
    chk("i0_2", 32'(PWM_DUTY2), 32'd6);

    // Handshake: busy ch2 refuses, idle ch3 accepts.
    CMD_CH = 2'd2; CMD_TARGET = 16'd0; CMD_STEP = 8'd0; CMD_INTERVAL = 8'd0;
    CMD_VALID = 1'b1;
    #1;
    chk("hs_ready_busy", 32'(CMD_READY), 32'h0);
    tick();
    CMD_VALID = 1'b0;
    pulse(4'h4);
    chk("hs_no_effect", 32'(PWM_DUTY2), 32'd9);
    CMD_CH = 2'd3; CMD_TARGET = 16'd7;
    #1;
    chk("hs_ready_idle", 32'(CMD_READY), 32'h1);
    send(2'd3, 16'd7, 8'd0, 8'd0);
    chk("hs_busy3", 32'(FADE_BUSY), 32'hC);

    // Contention: all four pending together. Last grant was ch2, so the
    // order is 3, 0, 1, 2.
    send(2'd0, 16'd20, 8'd1, 8'd1);
    send(2'd1, 16'd0, 8'd1, 8'd1);
    chk("rr_all_busy", 32'(FADE_BUSY), 32'hF);
    PWM_PERIOD_END = 4'hF;
    tick();
    PWM_PERIOD_END = '0;
    tick();
    chk("rr_e1_ch3", 32'(PWM_DUTY3), 32'd7);
    chk("rr_e1_ch0", 32'(PWM_DUTY0), 32'd5);
    chk("rr_e1_done", 32'(FADE_DONE), 32'h8);
    tick();
    chk("rr_e2_ch0", 32'(PWM_DUTY0), 32'd6);
    chk("rr_e2_ch1", 32'(PWM_DUTY1), 32'hFFFF);
    tick();
    chk("rr_e3_ch1", 32'(PWM_DUTY1), 32'hFFFE);
    chk("rr_e3_ch2", 32'(PWM_DUTY2), 32'd9);
    tick();
    chk("rr_e4_ch2", 32'(PWM_DUTY2), 32'd10);
    chk("rr_e4_done", 32'(FADE_DONE), 32'h4);
    // Second burst: ch0 and ch1 pending; ch0 comes first after ch2.
    PWM_PERIOD_END = 4'hF;
    tick();
    PWM_PERIOD_END = '0;
    tick();
    chk("rr2_e1_ch0", 32'(PWM_DUTY0), 32'd7);
    chk("rr2_e1_ch1", 32'(PWM_DUTY1), 32'hFFFE);
    tick();
    chk("rr2_e2_ch1", 32'(PWM_DUTY1), 32'hFFFD);

    // Abort while pending: the abort beats the grant, duties hold, no done.
    PWM_PERIOD_END = 4'h3;
    tick();
    PWM_PERIOD_END = '0;
    FADE_ABORT = 4'h3;
    tick();
    FADE_ABORT = '0;
    chk("ab_duty0", 32'(PWM_DUTY0), 32'd7);
    chk("ab_duty1", 32'(PWM_DUTY1), 32'hFFFD);
    chk("ab_busy", 32'(FADE_BUSY), 32'h0);
    chk("ab_done", 32'(FADE_DONE), 32'h0);
    pulse(4'h3);
    chk("ab_idle_pe", 32'(PWM_DUTY1), 32'hFFFD);
    tick();
    chk("ab_no_done", 32'(FADE_DONE), 32'h0);

    // Accept and abort on the same channel in one cycle: abort wins.
    CMD_CH = 2'd0; CMD_TARGET = 16'd50; CMD_STEP = 8'd1; CMD_INTERVAL = 8'd1;
    CMD_VALID = 1'b1; FADE_ABORT = 4'h1;
    #1;
    chk("aa_ready", 32'(CMD_READY), 32'h1);
    tick();
    CMD_VALID = 1'b0; FADE_ABORT = '0;
    chk("aa_dropped", 32'(FADE_BUSY), 32'h0);

    // Reset mid-fade clears duties immediately, without a clock edge.
    send(2'd0, 16'd500, 8'd10, 8'd1);
    pulse(4'h1);
    chk("rs_pre", 32'(PWM_DUTY0), 32'd17);
    #2;
    RST_N = 1'b0;
    #1;
    chk("rs_duty0", 32'(PWM_DUTY0), 32'd0);
    chk("rs_duty1", 32'(PWM_DUTY1), 32'd0);
    chk("rs_busy", 32'(FADE_BUSY), 32'h0);
    chk("rs_done", 32'(FADE_DONE), 32'h0);
    #1;
    RST_N = 1'b1;
    tick();
    chk("rs_after", 32'(PWM_DUTY0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 SHALL have parameter P_DUTY_W, default 16: duty/target width, matching the pwm_core PWM_DUTYn width.
REQ-002 SHALL have parameter P_CNT_W, default 8: width of the step size and of the interval field.
REQ-003 SHALL have one clock; reset is asynchronous and active-low (CLK, RST_N).
REQ-004 CLK  input  1  clock, rising-edge.
REQ-005 RST_N  input  1  asynchronous active-low reset.
REQ-006 PWM_PERIOD_END  input  4  per-channel 1-cycle pulse at pwm_core period wrap.
REQ-007 CMD_VALID  input  1  fade command valid.
REQ-008 CMD_READY  output  1  command accept.
REQ-009 CMD_CH  input  2  target channel.
REQ-010 CMD_TARGET  input  P_DUTY_W  final duty.
REQ-011 CMD_STEP  input  P_CNT_W  duty increment per update.
REQ-012 CMD_INTERVAL  input  P_CNT_W  periods between updates.
REQ-013 FADE_ABORT  input  4  per-channel abort pulse.
REQ-014 PWM_DUTY0..PWM_DUTY3  output  P_DUTY_W each  registered duty, drives pwm_core.
REQ-015 FADE_BUSY  output  4  channel fading.
REQ-016 FADE_DONE  output  4  1-cycle pulse on fade completion.

Function
REQ-017 Each channel SHALL have a 2-state FSM: IDLE and FADING; FADE_BUSY[n] SHALL equal (state==FADING).
REQ-018 CMD_READY SHALL equal !FADE_BUSY[CMD_CH]; a command is accepted only on CMD_VALID && CMD_READY at a rising edge.
REQ-019 On accept, the channel SHALL latch target, step and interval, clear its interval counter and pending flag, and go IDLE->FADING; PWM_DUTYn SHALL be unchanged by the accept itself.
REQ-020 CMD_INTERVAL=0 SHALL be treated as 1; CMD_STEP=0 SHALL make the first update jump directly to the target.
REQ-021 In FADING, each PWM_PERIOD_END[n] pulse SHALL increment the interval counter; the pulse that makes the count equal the interval SHALL clear the counter and set pending[n] at the same edge.
REQ-022 PERIOD_END pulses arriving while pending[n] is set SHALL still count; a second pending event before service SHALL coalesce (no queue).
REQ-023 A single shared update unit SHALL serve at most one pending channel per cycle, chosen by a round-robin arbiter: highest priority is the channel after the last granted; after reset, channel 0 has highest priority.
REQ-024 Granted update, d=PWM_DUTYn, t=target, s=step: if |t-d|<=s or s==0, PWM_DUTYn<=t, FADE_DONE[n]=1 for one cycle, ->IDLE; else PWM_DUTYn<=d+s if t>d, else d-s.
REQ-025 Difference and compare SHALL use P_DUTY_W+1-bit arithmetic; PWM_DUTYn SHALL never overshoot the target and never wrap.
REQ-026 A command whose target equals the current duty SHALL complete, with FADE_DONE, at its first granted update.
REQ-027 Latency: pending set at edge k -> PWM_DUTYn updated at edge k+1 if no contention, at latest edge k+4; pending[n] cleared at the update edge.
REQ-028 FADE_ABORT[n] in FADING SHALL go IDLE at the next edge, clearing pending; PWM_DUTYn holds; no FADE_DONE; abort overrides a same-cycle grant to n.
REQ-029 FADE_ABORT[n] in IDLE SHALL have no effect; an accept and abort on the same channel in the same cycle SHALL give abort priority (command dropped, still handshaken).
REQ-030 Inputs SHALL be synchronous to CLK; PWM_PERIOD_END in IDLE SHALL be ignored.

Reset
REQ-031 RST_N low SHALL asynchronously set PWM_DUTY0..3=0, FADE_BUSY=0, FADE_DONE=0, all counters, pending flags and latched fields to 0, and RR pointer to channel 0; CMD_READY is therefore 1.
REQ-032 Reset asserted mid-fade SHALL abandon the fade with no FADE_DONE; operation resumes on the first edge after release.

Verification
REQ-033 Ramp-up: ch0, target=100, step=30, interval=2, 8 PERIOD_END[0] pulses -> duty 30,60,90,100 after pulses 2,4,6,8; FADE_DONE[0] once with final update.
REQ-034 Ramp-down/no overshoot: duty0=100, target=5, step=40, interval=1 -> 60,20,5; never below 5.
REQ-035 Contention: all 4 channels pending at same edge -> updates on 4 consecutive edges in RR order; next burst starts after last granted.
REQ-036 Handshake: CMD_VALID to busy ch2 -> CMD_READY=0, no effect; same command to idle ch3 accepted same cycle.
REQ-037 Abort/reset: FADE_ABORT[1] mid-fade -> duty holds, BUSY[1]=0, no DONE; RST_N low mid-fade -> all duties 0 immediately.
REQ-038 Edge params: step=0 target=0xFFFF -> single jump to 0xFFFF at first interval; interval=0 -> update every PERIOD_END.
